rom_port_arbiter: RTL and testbench
===================================

# rom_port_arbiter

Two-master Avalon arbiter that shares one single-port, registered-read memory port between two requesters. Typical use is CPU instruction fetch (M0) and data/DMA access (M1) sharing one ROM/RAM bank. It resolves contention each cycle, stalls the loser with WaitRequest, and forwards the write strobe. It steers the fixed-latency (1 cycle) read data back to the master that issued the read. Fairness is round-robin, or fixed-priority with a starvation guard.

## Interface
Parameters:
- ADDR_SEL_BITS, 6, slave-select bits stripped upstream; word address width = 30-ADDR_SEL_BITS
- PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority M0 with starvation guard
- MAX_WAIT, 4, mode 1 only: consecutive stalled cycles of M1 before M1 is forced to win (1..15)

Ports:
- i_Clk  in  1  clock, all state on rising edge
- i_Rst_n  in  1  reset, asynchronous, active-low
- i_M0_SlaveSel / i_M1_SlaveSel  in  1  master selects this slave
- i_M0_RegAddr / i_M1_RegAddr  in  30-ADDR_SEL_BITS  word address
- i_M0_Read / i_M1_Read  in  1  read request
- i_M0_Write / i_M1_Write  in  1  write request
- i_M0_WriteData / i_M1_WriteData  in  32  write data
- i_M0_ByteEnable / i_M1_ByteEnable  in  4  byte lanes
- o_M0_ReadData / o_M1_ReadData  out  32  read data, valid 1 cycle after acceptance, else 0
- o_M0_WaitRequest / o_M1_WaitRequest  out  1  stall; master holds request while high
- o_Mem_Addr  out  30-ADDR_SEL_BITS  memory word address
- o_Mem_Read  out  1  memory read strobe
- o_Mem_Write  out  1  memory write strobe
- o_Mem_WriteData  out  32  memory write data
- o_Mem_ByteEnable  out  4  memory byte lanes
- i_Mem_ReadData  in  32  memory read data, registered, 1 cycle after o_Mem_Read

## Operation
- Request: ReqX = SlaveSel & (Read | Write). If Read and Write are both high, the access is a write and the read is ignored.
- Grant is combinational each cycle:
  - Only one ReqX high: that master wins.
  - Both high, mode 0: the master not recorded in LastGrant wins.
  - Both high, mode 1: M0 wins, unless WaitCnt = MAX_WAIT, in which case M1 wins.
- Winner: Addr, WriteData and ByteEnable are muxed to o_Mem_*. o_Mem_Read = winner Read & ~winner Write. o_Mem_Write = winner Write. The winner's WaitRequest = 0, and the transfer is accepted this cycle.
- Loser: WaitRequest = 1. Nothing is issued for the loser.
- Non-requesting master: WaitRequest = 0.
- Idle (no request): o_Mem_Read = o_Mem_Write = 0. o_Mem_Addr, WriteData and ByteEnable = 0.
- Registered state:
  - LastGrant (1 bit): updated to the winner on every accepted access.
  - RdOwner (2 bits: none/M0/M1): set to the winner when o_Mem_Read = 1, else none.
  - WaitCnt (4 bits): increments, saturating at MAX_WAIT, while M1 is stalled. It clears to 0 when M1 is granted or Req1 = 0.
- Read return: o_MX_ReadData = i_Mem_ReadData when RdOwner = X, else 0. Routing is combinational; no extra latency.
- Writes produce no return data.

## Timing
- Accepted read in cycle N: data appears on o_MX_ReadData in cycle N+1 only. This is identical to the memory's native latency.
- Back-to-back reads by the same master are accepted every cycle, one per cycle, at full throughput.
- Contention, mode 0: strict alternation, M0, M1, M0, … Each master waits at most 1 cycle.
- Contention, mode 1: M1 is granted at most every MAX_WAIT+1 cycles under continuous M0 load.
- A read accepted in N and a write by the other master accepted in N+1: the read data is still routed to the read owner in N+1.
- While i_Rst_n = 0:
  - LastGrant = M1, so M0 wins the first contention.
  - RdOwner = none, WaitCnt = 0.
  - o_Mem_Read = o_Mem_Write = 0.
  - Both o_MX_ReadData = 0.
  - o_MX_WaitRequest = ReqX, so any requester stalls.
- Reset asserted between acceptance and return: RdOwner clears immediately (asynchronous). The in-flight data is dropped and both ReadData outputs stay 0.
- Release of reset: normal arbitration from the first rising edge with i_Rst_n = 1.

## Test plan
- Single master read: M0 reads addr 0x10 (memory model returns 0x00112623) -> WaitRequest0 = 0. o_Mem_Read = 1 with o_Mem_Addr = 0x10 in cycle N. o_M0_ReadData = 0x00112623 in N+1. o_M1_ReadData = 0 throughout.
- Round-robin contention (mode 0): both read continuously from reset, M0 at 0x1, M1 at 0x2 -> grants M0, M1, M0, M1. WaitRequest alternates 0/1 and 1/0. Each ReadData carries only its own address's data.
- Fixed-priority starvation (mode 1, MAX_WAIT = 4): both request continuously -> M0 granted 4 cycles, M1 granted on the 5th, repeating. WaitCnt never exceeds 4.
- Write/read mix: M0 writes 0xDEADBEEF with ByteEnable 0xF at 0x20 while M1 reads 0x20 -> M0 wins (first contention). o_Mem_Write = 1 with data 0xDEADBEEF. M1 is accepted next cycle and returns 0xDEADBEEF one cycle later.
- Read+Write both high on M1, alone -> o_Mem_Write = 1, o_Mem_Read = 0, and o_M1_ReadData stays 0 the next cycle.
- Reset mid-read: M1 read accepted in N, i_Rst_n low mid-cycle N+1 -> o_M1_ReadData = 0 immediately. Requesters see WaitRequest = 1 until release. The first contention after release goes to M0.

Source files
------------

// File: rtl/rom_port_arbiter_if.sv
// rom_port_arbiter_if: two Avalon master ports plus the shared memory port of the arbiter
interface rom_port_arbiter_if #(parameter int AW = 24);
  logic          i_M0_SlaveSel, i_M1_SlaveSel;
  logic [AW-1:0] i_M0_RegAddr, i_M1_RegAddr;
  logic          i_M0_Read, i_M1_Read;
  logic          i_M0_Write, i_M1_Write;
  logic [31:0]   i_M0_WriteData, i_M1_WriteData;
  logic [3:0]    i_M0_ByteEnable, i_M1_ByteEnable;
  logic [31:0]   o_M0_ReadData, o_M1_ReadData;
  logic          o_M0_WaitRequest, o_M1_WaitRequest;
  logic [AW-1:0] o_Mem_Addr;
  logic          o_Mem_Read, o_Mem_Write;
  logic [31:0]   o_Mem_WriteData;
  logic [3:0]    o_Mem_ByteEnable;
  logic [31:0]   i_Mem_ReadData;
  modport slave (
    input  i_M0_SlaveSel, i_M1_SlaveSel, i_M0_RegAddr, i_M1_RegAddr, i_M0_Read, i_M1_Read,
           i_M0_Write, i_M1_Write, i_M0_WriteData, i_M1_WriteData, i_M0_ByteEnable,
           i_M1_ByteEnable, i_Mem_ReadData,
    output o_M0_ReadData, o_M1_ReadData, o_M0_WaitRequest, o_M1_WaitRequest, o_Mem_Addr,
           o_Mem_Read, o_Mem_Write, o_Mem_WriteData, o_Mem_ByteEnable
  );
  modport master (
    output i_M0_SlaveSel, i_M1_SlaveSel, i_M0_RegAddr, i_M1_RegAddr, i_M0_Read, i_M1_Read,
           i_M0_Write, i_M1_Write, i_M0_WriteData, i_M1_WriteData, i_M0_ByteEnable,
           i_M1_ByteEnable, i_Mem_ReadData,
    input  o_M0_ReadData, o_M1_ReadData, o_M0_WaitRequest, o_M1_WaitRequest, o_Mem_Addr,
           o_Mem_Read, o_Mem_Write, o_Mem_WriteData, o_Mem_ByteEnable
  );
endinterface

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one registered-read memory port between two Avalon masters
module rom_port_arbiter #(
  parameter int ADDR_SEL_BITS = 6,
  parameter int PRIORITY_MODE = 0,
  parameter int MAX_WAIT      = 4
) (
  input logic i_Clk,
  input logic i_Rst_n,
  rom_port_arbiter_if.slave bus
);
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  logic       req0, req1, act, w1, win_rd, win_wr, mem_rd;
  logic       last_q, last_d;
  logic [1:0] own_q, own_d;
  logic [3:0] wait_q, wait_d;
  always_comb begin
    req0   = bus.i_M0_SlaveSel & (bus.i_M0_Read | bus.i_M0_Write);
    req1   = bus.i_M1_SlaveSel & (bus.i_M1_Read | bus.i_M1_Write);
    act    = i_Rst_n & (req0 | req1);
    w1     = req1 & (~req0 | (PRIORITY_MODE == 0 ? ~last_q : wait_q == MW));
    win_rd = w1 ? bus.i_M1_Read : bus.i_M0_Read;
    win_wr = w1 ? bus.i_M1_Write : bus.i_M0_Write;
    mem_rd = act & win_rd & ~win_wr;
    bus.o_Mem_Read       = mem_rd;
    bus.o_Mem_Write      = act & win_wr;
    bus.o_Mem_Addr       = act ? (w1 ? bus.i_M1_RegAddr : bus.i_M0_RegAddr) : '0;
    bus.o_Mem_WriteData  = act ? (w1 ? bus.i_M1_WriteData : bus.i_M0_WriteData) : '0;
    bus.o_Mem_ByteEnable = act ? (w1 ? bus.i_M1_ByteEnable : bus.i_M0_ByteEnable) : '0;
    // in reset every requester stalls
    bus.o_M0_WaitRequest = req0 & (~i_Rst_n | w1);
    bus.o_M1_WaitRequest = req1 & (~i_Rst_n | ~w1);
    bus.o_M0_ReadData    = own_q == 2'd1 ? bus.i_Mem_ReadData : '0;
    bus.o_M1_ReadData    = own_q == 2'd2 ? bus.i_Mem_ReadData : '0;
    last_d = act ? w1 : last_q;
    own_d  = mem_rd ? (w1 ? 2'd2 : 2'd1) : 2'd0;
    wait_d = (req1 & ~w1) ? (wait_q == MW ? wait_q : wait_q + 4'd1) : 4'd0;
  end
  always_ff @(posedge i_Clk or negedge i_Rst_n)
    if (!i_Rst_n) begin
      last_q <= 1'b1;
      own_q  <= 2'd0;
      wait_q <= 4'd0;
    end else begin
      last_q <= last_d;
      own_q  <= own_d;
      wait_q <= wait_d;
    end
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: directed bench for round-robin and fixed-priority arbiters against a behavioural model
module tb_rom_port_arbiter;
  localparam int MW = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic s0 = 0, r0 = 0, w0 = 0, s1 = 0, r1 = 0, w1 = 0;
  logic [23:0] a0 = '0, a1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  logic [3:0]  b0 = '0, b1 = '0;
  int checks = 0, passes = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passes++;
  endtask

  function automatic logic [31:0] init_val(input int i);
    return (i == 16) ? 32'h00112623 : {8'hA5, 8'(i), 8'(i ^ 8'h5A), 8'(i)};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    rom_port_arbiter_if #(.AW(24)) bus ();
    rom_port_arbiter #(.ADDR_SEL_BITS(6), .PRIORITY_MODE(g), .MAX_WAIT(MW)) dut (
      .i_Clk(clk), .i_Rst_n(rst_n), .bus(bus));
    assign bus.i_M0_SlaveSel = s0;
    assign bus.i_M1_SlaveSel = s1;
    assign bus.i_M0_Read = r0;
    assign bus.i_M1_Read = r1;
    assign bus.i_M0_Write = w0;
    assign bus.i_M1_Write = w1;
    assign bus.i_M0_RegAddr = a0;
    assign bus.i_M1_RegAddr = a1;
    assign bus.i_M0_WriteData = d0;
    assign bus.i_M1_WriteData = d1;
    assign bus.i_M0_ByteEnable = b0;
    assign bus.i_M1_ByteEnable = b1;
    // memory with one-cycle registered read
    logic [31:0] mem [256];
    logic [31:0] rdata = '0;
    logic init_done = 1'b0;
    assign bus.i_Mem_ReadData = rdata;
    always @(posedge clk)
      if (!init_done) begin
        for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        init_done <= 1'b1;
      end else begin
        if (bus.o_Mem_Write)
          for (int b = 0; b < 4; b++)
            if (bus.o_Mem_ByteEnable[b]) mem[bus.o_Mem_Addr[7:0]][8*b+:8] <= bus.o_Mem_WriteData[8*b+:8];
        if (bus.o_Mem_Read) rdata <= mem[bus.o_Mem_Addr[7:0]];
      end
    // behavioural model: who should win now, and which read is in flight
    int m_last = 1, m_stall = 0, m_own = -1;
    logic [31:0] m_data = '0;
    logic q0, q1, many, mw1, e_rd, e_wr;
    assign q0   = s0 & (r0 | w0);
    assign q1   = s1 & (r1 | w1);
    assign many = rst_n & (q0 | q1);
    assign mw1  = q1 && (!q0 || (g == 0 ? m_last == 0 : m_stall >= MW));
    assign e_rd = many & (mw1 ? (r1 & !w1) : (r0 & !w0));
    assign e_wr = many & (mw1 ? w1 : w0);
    always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        m_last <= 1;
        m_stall <= 0;
        m_own <= -1;
      end else begin
        if (many) m_last <= int'(mw1);
        m_stall <= (q1 && !mw1) ? ((m_stall < MW) ? m_stall + 1 : m_stall) : 0;
        m_own <= e_rd ? int'(mw1) : -1;
        if (e_rd) m_data <= mem[(mw1 ? a1[7:0] : a0[7:0])];
      end
    always @(negedge clk) begin
      chk($sformatf("u%0d.wait0", g), 32'(bus.o_M0_WaitRequest), 32'(q0 & ~(many & ~mw1)));
      chk($sformatf("u%0d.wait1", g), 32'(bus.o_M1_WaitRequest), 32'(q1 & ~(many & mw1)));
      chk($sformatf("u%0d.mem_rd", g), 32'(bus.o_Mem_Read), 32'(e_rd));
      chk($sformatf("u%0d.mem_wr", g), 32'(bus.o_Mem_Write), 32'(e_wr));
      chk($sformatf("u%0d.mem_addr", g), 32'(bus.o_Mem_Addr), many ? 32'(mw1 ? a1 : a0) : 32'h0);
      chk($sformatf("u%0d.mem_wd", g), bus.o_Mem_WriteData, many ? (mw1 ? d1 : d0) : 32'h0);
      chk($sformatf("u%0d.mem_be", g), 32'(bus.o_Mem_ByteEnable), many ? 32'(mw1 ? b1 : b0) : 32'h0);
      chk($sformatf("u%0d.rd0", g), bus.o_M0_ReadData, m_own == 0 ? m_data : 32'h0);
      chk($sformatf("u%0d.rd1", g), bus.o_M1_ReadData, m_own == 1 ? m_data : 32'h0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    s0 = 0; r0 = 0; w0 = 0; s1 = 0; r1 = 0; w1 = 0;
  endtask

  initial begin
    tick;
    s0 = 1; r0 = 1; #2;
    chk("rst_wait0", 32'(u[0].bus.o_M0_WaitRequest), 32'h1);
    chk("rst_memrd", 32'(u[0].bus.o_Mem_Read), 32'h0);
    chk("rst_rd0", u[0].bus.o_M0_ReadData, 32'h0);
    idle;
    tick;
    rst_n = 1;
    tick;
    s0 = 1; r0 = 1; a0 = 24'h10; #2;
    chk("sr_wait0", 32'(u[0].bus.o_M0_WaitRequest), 32'h0);
    chk("sr_memrd", 32'(u[0].bus.o_Mem_Read), 32'h1);
    chk("sr_addr", 32'(u[0].bus.o_Mem_Addr), 32'h10);
    tick;
    idle; #2;
    chk("sr_rd0", u[0].bus.o_M0_ReadData, 32'h00112623);
    chk("sr_rd1", u[0].bus.o_M1_ReadData, 32'h0);
    rst_n = 0; #1; rst_n = 1;
    tick;
    s0 = 1; r0 = 1; a0 = 24'h1; s1 = 1; r1 = 1; a1 = 24'h2;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk("rr_wait0", 32'(u[0].bus.o_M0_WaitRequest), 32'(i % 2));
      chk("rr_wait1", 32'(u[0].bus.o_M1_WaitRequest), 32'(1 - i % 2));
      chk("sp_wait1", 32'(u[1].bus.o_M1_WaitRequest), (i % 5 == 4) ? 32'h0 : 32'h1);
      if (i == 1) chk("rr_rd0", u[0].bus.o_M0_ReadData, 32'hA5015B01);
      if (i == 2) chk("rr_rd1", u[0].bus.o_M1_ReadData, 32'hA5025802);
      tick;
    end
    idle;
    rst_n = 0; #1; rst_n = 1;
    tick;
    s0 = 1; w0 = 1; a0 = 24'h20; d0 = 32'hDEADBEEF; b0 = 4'hF;
    s1 = 1; r1 = 1; a1 = 24'h20; #2;
    chk("wr_memwr", 32'(u[0].bus.o_Mem_Write), 32'h1);
    chk("wr_data", u[0].bus.o_Mem_WriteData, 32'hDEADBEEF);
    chk("wr_wait1", 32'(u[0].bus.o_M1_WaitRequest), 32'h1);
    tick;
    s0 = 0; w0 = 0; #2;
    chk("wr_wait1b", 32'(u[0].bus.o_M1_WaitRequest), 32'h0);
    chk("wr_memrd", 32'(u[0].bus.o_Mem_Read), 32'h1);
    tick;
    idle; #2;
    chk("wr_rd1", u[0].bus.o_M1_ReadData, 32'hDEADBEEF);
    tick;
    s1 = 1; r1 = 1; w1 = 1; a1 = 24'h30; d1 = 32'h12345678; b1 = 4'h3; #2;
    chk("rw_memwr", 32'(u[0].bus.o_Mem_Write), 32'h1);
    chk("rw_memrd", 32'(u[0].bus.o_Mem_Read), 32'h0);
    tick;
    idle; #2;
    chk("rw_rd1", u[0].bus.o_M1_ReadData, 32'h0);
    tick;
    s1 = 1; r1 = 1; a1 = 24'h10; #2;
    chk("mr_memrd", 32'(u[0].bus.o_Mem_Read), 32'h1);
    tick;
    s0 = 1; r0 = 1; a0 = 24'h1; #2;
    chk("mr_rd1", u[0].bus.o_M1_ReadData, 32'h00112623);
    rst_n = 0; #1;
    chk("mr_rd1_rst", u[0].bus.o_M1_ReadData, 32'h0);
    chk("mr_wait0_rst", 32'(u[0].bus.o_M0_WaitRequest), 32'h1);
    chk("mr_wait1_rst", 32'(u[0].bus.o_M1_WaitRequest), 32'h1);
    tick; #2;
    chk("mr_wait1_hold", 32'(u[1].bus.o_M1_WaitRequest), 32'h1);
    rst_n = 1; #1;
    chk("mr_rel_wait0", 32'(u[0].bus.o_M0_WaitRequest), 32'h0);
    chk("mr_rel_wait1", 32'(u[0].bus.o_M1_WaitRequest), 32'h1);
    tick;
    idle;
    tick;
    tick;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
